// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
//   Sequencer that feeds a 3x3 conv_unit from a raster pixel stream. A frame
//   loads nine kernel weights, then streams IMG_W x IMG_H pixels through two
//   line buffers to build a sliding 3x3 window. Each fully-inside window is
//   presented on win_a and flagged with win_valid. conv_unit returns its result
//   CONV_LAT cycles later, and that result is re-timed onto res_data/res_valid.
//   Only valid (no-padding) convolution is produced.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle frame start pulse (accepted only in IDLE)
//   busy, done          frame in progress / one-cycle completion pulse
//   w_valid/w_ready/w_data       weight stream, b00..b22 row-major
//   pix_valid/pix_ready/pix_data pixel stream, raster order
//   win_a, win_b        window and weights to conv_unit, a00/b00 in the LSBs
//   win_valid           win_a holds a complete window this cycle
//   conv_out            conv_unit result
//   res_data, res_valid re-timed convolution result stream
//
// Optional feature (macro CONV_STATS_EN)
//   res_cnt             number of results produced in the current frame
//   res_max             largest unsigned result seen in the current frame
module conv_window_ctrl #(
   parameter int WIDTH    = 9,
   parameter int IMG_W    = 8,
   parameter int IMG_H    = 8,
   parameter int CONV_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   input  logic                 w_valid,
   output logic                 w_ready,
   input  logic [WIDTH-1:0]     w_data,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   input  logic [WIDTH-1:0]     pix_data,
   output logic [9*WIDTH-1:0]   win_a,
   output logic [9*WIDTH-1:0]   win_b,
   output logic                 win_valid,
   input  logic [2*WIDTH-1:0]   conv_out,
   output logic [2*WIDTH-1:0]   res_data,
   output logic                 res_valid
`ifdef CONV_STATS_EN
   ,
   output logic [15:0]          res_cnt,
   output logic [2*WIDTH-1:0]   res_max
`endif
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int DW = $clog2(CONV_LAT + 2);

   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_TWO   = CW'(2);
   localparam logic [RW-1:0] ROW_TWO   = RW'(2);
   localparam logic [DW-1:0] DRAIN_END = DW'(CONV_LAT);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      FIN    = 3'd4
   } state_t;

   state_t           state_r;
   logic [3:0]       k_r;
   logic [CW-1:0]    col_r;
   logic [RW-1:0]    row_r;
   logic [DW-1:0]    drain_r;
   logic [WIDTH-1:0] wgt_r [9];
   // win_r[row][col]: row 0 is the oldest image row, col 0 the oldest column
   logic [WIDTH-1:0] win_r [3][3];
   // lb0 holds image row r-1, lb1 holds row r-2, both indexed by column
   logic [WIDTH-1:0] lb0_r [IMG_W];
   logic [WIDTH-1:0] lb1_r [IMG_W];

   logic pix_acc_s;
   logic start_acc_s;
   logic dly_valid_s;

   assign pix_acc_s   = (state_r == STREAM) && pix_valid && pix_ready;
   assign start_acc_s = (state_r == IDLE) && start;

   // Frame sequencer: state, counters, weight and window registers, handshakes
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         k_r       <= 4'd0;
         col_r     <= {CW{1'b0}};
         row_r     <= {RW{1'b0}};
         drain_r   <= {DW{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
         w_ready   <= 1'b0;
         pix_ready <= 1'b0;
         win_valid <= 1'b0;
         for (int k = 0; k < 9; k++) begin
            wgt_r[k] <= {WIDTH{1'b0}};
         end
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               win_r[i][j] <= {WIDTH{1'b0}};
            end
         end
      end else begin
         done      <= 1'b0;
         win_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r <= LOAD_W;
                  busy    <= 1'b1;
                  w_ready <= 1'b1;
                  k_r     <= 4'd0;
               end
            end
            LOAD_W: begin
               if (w_valid && w_ready) begin
                  wgt_r[k_r] <= w_data;
                  if (k_r == 4'd8) begin
                     state_r   <= STREAM;
                     w_ready   <= 1'b0;
                     pix_ready <= 1'b1;
                     col_r     <= {CW{1'b0}};
                     row_r     <= {RW{1'b0}};
                  end else begin
                     k_r <= k_r + 4'd1;
                  end
               end
            end
            STREAM: begin
               if (pix_acc_s) begin
                  for (int i = 0; i < 3; i++) begin
                     win_r[i][0] <= win_r[i][1];
                     win_r[i][1] <= win_r[i][2];
                  end
                  win_r[0][2] <= lb1_r[col_r];
                  win_r[1][2] <= lb0_r[col_r];
                  win_r[2][2] <= pix_data;
                  // Columns 0/1 of a row still carry the previous row's tail,
                  // so only c>=2 on rows r>=2 forms a genuine window.
                  win_valid <= (row_r >= ROW_TWO) && (col_r >= COL_TWO);
                  if (col_r == COL_LAST) begin
                     col_r <= {CW{1'b0}};
                     if (row_r == ROW_LAST) begin
                        state_r   <= DRAIN;
                        pix_ready <= 1'b0;
                        drain_r   <= {DW{1'b0}};
                     end else begin
                        row_r <= row_r + {{(RW-1){1'b0}}, 1'b1};
                     end
                  end else begin
                     col_r <= col_r + {{(CW-1){1'b0}}, 1'b1};
                  end
               end
            end
            DRAIN: begin
               // CONV_LAT+1 cycles covers conv_unit latency plus the result register
               if (drain_r == DRAIN_END) begin
                  state_r <= FIN;
                  done    <= 1'b1;
               end else begin
                  drain_r <= drain_r + {{(DW-1){1'b0}}, 1'b1};
               end
            end
            FIN: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r   <= IDLE;
               busy      <= 1'b0;
               w_ready   <= 1'b0;
               pix_ready <= 1'b0;
            end
         endcase
      end
   end

   // Line buffers: contents are don't-care after reset, so no reset branch
   always_ff @(posedge clk) begin
      if (pix_acc_s) begin
         lb1_r[col_r] <= lb0_r[col_r];
         lb0_r[col_r] <= pix_data;
      end
   end

   // Pack window and weight registers onto the conv_unit buses
   always_comb begin
      win_a = {(9*WIDTH){1'b0}};
      win_b = {(9*WIDTH){1'b0}};
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            win_a[(i*3+j)*WIDTH +: WIDTH] = win_r[i][j];
            win_b[(i*3+j)*WIDTH +: WIDTH] = wgt_r[i*3+j];
         end
      end
   end

   generate
      if (CONV_LAT == 0) begin : g_no_dly
         assign dly_valid_s = win_valid;
      end else begin : g_dly
         logic [CONV_LAT-1:0] vd_r;

         // Valid delay line matching the conv_unit pipeline depth
         always_ff @(posedge clk) begin
            if (rst) begin
               vd_r <= {CONV_LAT{1'b0}};
            end else begin
               vd_r[0] <= win_valid;
               for (int i = 1; i < CONV_LAT; i++) begin
                  vd_r[i] <= vd_r[i-1];
               end
            end
         end

         assign dly_valid_s = vd_r[CONV_LAT-1];
      end
   endgenerate

   // Result register: capture conv_out when the delayed valid lines up with it
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_data  <= {(2*WIDTH){1'b0}};
      end else begin
         res_valid <= dly_valid_s;
         if (dly_valid_s) begin
            res_data <= conv_out;
         end else begin
            res_data <= res_data;
         end
      end
   end

`ifdef CONV_STATS_EN
   // Per-frame statistics, updated on the same edge that loads res_data
   always_ff @(posedge clk) begin
      if (rst || start_acc_s) begin
         res_cnt <= 16'd0;
         res_max <= {(2*WIDTH){1'b0}};
      end else if (dly_valid_s) begin
         res_cnt <= res_cnt + 16'd1;
         if (conv_out > res_max) begin
            res_max <= conv_out;
         end else begin
            res_max <= res_max;
         end
      end else begin
         res_cnt <= res_cnt;
         res_max <= res_max;
      end
   end
`endif

endmodule
